eggtimer_datapath: RTL and testbench
====================================

Name: eggtimer_datapath

Overview:
- Countdown datapath for the egg timer. It is the counterpart of the egg timer controller: it consumes `load`, `start` and `countdown`, and returns `zero` and `endd`.
- Holds a BCD mm:ss count, derives a 1 s tick from the system clock, decrements while enabled, and flags end-of-time.
- Drives the 4-digit display values and a timed alarm output.

Parameters:
- TICK_DIV, 100000000, clock cycles per 1 s tick; minimum 2; use 4 in simulation.
- ALARM_SEC, 5, number of ticks `alarm` stays high after end-of-time; 0 disables the alarm.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- load  in  1  level; copies preset into the counter.
- start  in  1  level; holds the prescaler cleared while high.
- countdown  in  1  level; run enable from the controller.
- set_min_t  in  4  preset minutes tens (BCD).
- set_min_o  in  4  preset minutes ones (BCD).
- set_sec_t  in  4  preset seconds tens (BCD).
- set_sec_o  in  4  preset seconds ones (BCD).
- min_t, min_o, sec_t, sec_o  out  4 each  current count (BCD), registered.
- zero  out  1  high when the count is 00:00; combinational from count registers.
- endd  out  1  registered end-of-time flag.
- alarm  out  1  registered alarm drive.
- tick  out  1  registered one-cycle pulse at each 1 s boundary while running.

Behaviour:
Reset (`rst` = 0, asynchronous):
- All count digits = 0, so `zero` = 1.
- `endd`, `alarm` and `tick` = 0.
- Prescaler and alarm counter = 0.

Priority each cycle is load > start > countdown > idle.

load = 1:
- The count takes the preset on the next edge.
- Clamping: any digit > 9 loads as 9; `set_sec_t` > 5 loads as 5.
- `endd`, `alarm`, prescaler and alarm counter clear to 0.
- No tick is issued.

start = 1 (with load = 0):
- Prescaler held at 0; count unchanged.
- The first decrement after `start` falls comes a full TICK_DIV cycles after `countdown` is seen high.

countdown = 1, start = 0, load = 0:
- Prescaler increments each cycle.
- When the prescaler equals TICK_DIV-1, it wraps to 0 and `tick` pulses on the next cycle.
- On the same edge as the wrap, the count decrements by 1 s, unless the count is already 00:00.

BCD decrement:
- `sec_o` 0→9 with borrow; otherwise -1.
- `sec_t` 0→5 with borrow on borrow-in.
- `min_o` 0→9 with borrow on borrow-in.
- `min_t` decrements on borrow-in.
- Examples: 10:00 → 09:59; 01:00 → 00:59.

End-of-time:
- If `countdown` = 1 and the count is 00:00 (or becomes 00:00 on this edge), `endd` is set on that edge.
- `endd` stays high until `load` or reset; it does not clear when `countdown` falls.
- Starting a countdown at 00:00 sets `endd` one cycle after `countdown` rises. There is no underflow and no wrap to 99:59.

Pause:
- `countdown` = 0 with load = 0 and start = 0 freezes the count and the prescaler (resume keeps the partial second).
- Exception: while `alarm` = 1, the prescaler keeps running so the alarm can time out.

Alarm:
- `alarm` rises on the edge where `endd` rises, if ALARM_SEC > 0.
- The alarm counter increments on each prescaler wrap while `alarm` = 1.
- `alarm` falls on the wrap where the counter reaches ALARM_SEC.
- Total alarm duration is ALARM_SEC × TICK_DIV cycles (±1).

Simultaneous events:
- load and end-of-time in the same cycle: load wins, `endd` stays 0.
- Reset mid-count: returns immediately to reset values.

Widths:
- Prescaler width is clog2(TICK_DIV).
- Alarm counter width is clog2(ALARM_SEC+1), minimum 1.

Test Plan (TICK_DIV=4, ALARM_SEC=2):
1. Reset, then load preset 01:05 → next edge shows min_t=0, min_o=1, sec_t=0, sec_o=5; `zero`=0; `endd`=0.
2. From 01:05, raise `countdown` → the count reads 01:04 at cycle 4; `tick` pulses at cycle 5; count is 00:59 after 6 ticks (cycle 24).
3. Load 00:02 with `countdown`=1 → 00:01 at cycle 4, 00:00 at cycle 8 with `endd`=1 and `alarm`=1 on the same edge; `alarm` falls 8 cycles later; `endd` holds.
4. Pause: at 00:05, drop `countdown` at prescaler=2 for 10 cycles, then raise it → 00:04 occurs 2 cycles after resume; the count is unchanged during the pause.
5. Preset 7F:9A (set_min_t=7, set_min_o=15, set_sec_t=9, set_sec_o=10) → loads as 79:59; hold `start` high with `countdown`=1 for 10 cycles → no decrement.
6. Assert `rst` low mid-count at 00:30 → all digits 0, `zero`=1, `endd`=0, `alarm`=0 asynchronously; load and `countdown` at 00:00 → `endd`=1 after 1 cycle, digits stay 00:00.

Source files
------------

// File: rtl/eggtimer_datapath.sv
// Egg timer countdown datapath: BCD mm:ss counter,
// 1 s prescaler, end-of-time flag and timed alarm.
module eggtimer_datapath #(
    parameter int TICK_DIV  = 100000000,
    parameter int ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       countdown,
    input  logic [3:0] set_min_t,
    input  logic [3:0] set_min_o,
    input  logic [3:0] set_sec_t,
    input  logic [3:0] set_sec_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       zero,
    output logic       endd,
    output logic       alarm,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] A_MAX = AW'(ALARM_SEC);
    localparam logic ALARM_EN = (ALARM_SEC > 0);

    logic [PW-1:0] presc;
    logic [AW-1:0] acnt;
    logic [AW-1:0] acnt_nxt;
    logic          wrap_q;
    logic          wrap;
    logic          run;
    logic          one_left;
    logic          hit_end;
    logic [3:0]    nxt_min_t;
    logic [3:0]    nxt_min_o;
    logic [3:0]    nxt_sec_t;
    logic [3:0]    nxt_sec_o;

    function automatic logic [3:0] clamp(input logic [3:0] d,
                                         input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign zero     = (min_t == 4'd0) && (min_o == 4'd0) &&
                      (sec_t == 4'd0) && (sec_o == 4'd0);
    assign one_left = (min_t == 4'd0) && (min_o == 4'd0) &&
                      (sec_t == 4'd0) && (sec_o == 4'd1);
    assign wrap     = (presc == P_LAST);
    assign run      = countdown | alarm;
    // End-of-time: already at 00:00, or reaching it on this wrap.
    assign hit_end  = countdown & (zero | (wrap & one_left));
    assign acnt_nxt = acnt + AW'(1);

    // BCD count minus one second, borrowing digit to digit.
    always_comb begin
        nxt_min_t = min_t;
        nxt_min_o = min_o;
        nxt_sec_t = sec_t;
        nxt_sec_o = sec_o;
        if (sec_o == 4'd0) begin
            nxt_sec_o = 4'd9;
            if (sec_t == 4'd0) begin
                nxt_sec_t = 4'd5;
                if (min_o == 4'd0) begin
                    nxt_min_o = 4'd9;
                    nxt_min_t = min_t - 4'd1;
                end else begin
                    nxt_min_o = min_o - 4'd1;
                end
            end else begin
                nxt_sec_t = sec_t - 4'd1;
            end
        end else begin
            nxt_sec_o = sec_o - 4'd1;
        end
    end

    // Count, prescaler, tick and end/alarm state, priority load > start > run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_t  <= 4'd0;
            min_o  <= 4'd0;
            sec_t  <= 4'd0;
            sec_o  <= 4'd0;
            presc  <= '0;
            acnt   <= '0;
            wrap_q <= 1'b0;
            tick   <= 1'b0;
            endd   <= 1'b0;
            alarm  <= 1'b0;
        end else if (load) begin
            min_t  <= clamp(set_min_t, 4'd9);
            min_o  <= clamp(set_min_o, 4'd9);
            sec_t  <= clamp(set_sec_t, 4'd5);
            sec_o  <= clamp(set_sec_o, 4'd9);
            presc  <= '0;
            acnt   <= '0;
            wrap_q <= 1'b0;
            tick   <= 1'b0;
            endd   <= 1'b0;
            alarm  <= 1'b0;
        end else if (start) begin
            presc  <= '0;
            wrap_q <= 1'b0;
            tick   <= wrap_q;
        end else begin
            tick   <= wrap_q;
            wrap_q <= 1'b0;
            if (run) begin
                presc <= wrap ? '0 : presc + PW'(1);
                if (wrap && countdown) begin
                    wrap_q <= 1'b1;
                    if (!zero) begin
                        min_t <= nxt_min_t;
                        min_o <= nxt_min_o;
                        sec_t <= nxt_sec_t;
                        sec_o <= nxt_sec_o;
                    end
                end
                if (wrap && alarm) begin
                    acnt <= acnt_nxt;
                    if (acnt_nxt == A_MAX) begin
                        alarm <= 1'b0;
                    end
                end
            end
            if (hit_end) begin
                endd <= 1'b1;
                if (!endd && ALARM_EN) begin
                    alarm <= 1'b1;
                    acnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eggtimer_datapath.sv
// Directed bench for eggtimer_datapath with
// TICK_DIV=4 and ALARM_SEC=2.
module tb_eggtimer_datapath;

    logic       clk;
    logic       rst;
    logic       load;
    logic       start;
    logic       countdown;
    logic [3:0] set_min_t;
    logic [3:0] set_min_o;
    logic [3:0] set_sec_t;
    logic [3:0] set_sec_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       zero;
    logic       endd;
    logic       alarm;
    logic       tick;
    logic [15:0] cnt;

    int errors = 0;
    int checks = 0;

    eggtimer_datapath #(
        .TICK_DIV (4),
        .ALARM_SEC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .start    (start),
        .countdown(countdown),
        .set_min_t(set_min_t),
        .set_min_o(set_min_o),
        .set_sec_t(set_sec_t),
        .set_sec_o(set_sec_o),
        .min_t    (min_t),
        .min_o    (min_o),
        .sec_t    (sec_t),
        .sec_o    (sec_o),
        .zero     (zero),
        .endd     (endd),
        .alarm    (alarm),
        .tick     (tick)
    );

    assign cnt = {min_t, min_o, sec_t, sec_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        set_min_t = a;
        set_min_o = b;
        set_sec_t = c;
        set_sec_o = d;
    endtask

    initial begin
        rst = 1'b0;
        load = 1'b0;
        start = 1'b0;
        countdown = 1'b0;
        preset(4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        chk("rst_cnt", cnt, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        chk("rst_endd", {15'd0, endd}, 16'd0);
        chk("rst_alarm", {15'd0, alarm}, 16'd0);
        chk("rst_tick", {15'd0, tick}, 16'd0);
        step(2);
        rst = 1'b1;
        step(1);

        // 1: load 01:05
        preset(4'd0, 4'd1, 4'd0, 4'd5);
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t1_cnt", cnt, 16'h0105);
        chk("t1_zero", {15'd0, zero}, 16'd0);
        chk("t1_endd", {15'd0, endd}, 16'd0);

        // 2: run from 01:05
        countdown = 1'b1;
        step(3);
        chk("t2_c3", cnt, 16'h0105);
        step(1);
        chk("t2_c4", cnt, 16'h0104);
        chk("t2_tick4", {15'd0, tick}, 16'd0);
        step(1);
        chk("t2_tick5", {15'd0, tick}, 16'd1);
        step(1);
        chk("t2_tick6", {15'd0, tick}, 16'd0);
        step(18);
        chk("t2_c24", cnt, 16'h0059);
        chk("t2_endd", {15'd0, endd}, 16'd0);

        // 3: load 00:02 while running, reach end, alarm times out
        preset(4'd0, 4'd0, 4'd0, 4'd2);
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t3_load", cnt, 16'h0002);
        step(4);
        chk("t3_c4", cnt, 16'h0001);
        chk("t3_endd4", {15'd0, endd}, 16'd0);
        step(4);
        chk("t3_c8", cnt, 16'h0000);
        chk("t3_zero8", {15'd0, zero}, 16'd1);
        chk("t3_endd8", {15'd0, endd}, 16'd1);
        chk("t3_alarm8", {15'd0, alarm}, 16'd1);
        step(7);
        chk("t3_alarm15", {15'd0, alarm}, 16'd1);
        chk("t3_c15", cnt, 16'h0000);
        step(1);
        chk("t3_alarm16", {15'd0, alarm}, 16'd0);
        chk("t3_endd16", {15'd0, endd}, 16'd1);

        // 4: pause at prescaler=2, resume keeps partial second
        preset(4'd0, 4'd0, 4'd0, 4'd5);
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t4_endd", {15'd0, endd}, 16'd0);
        step(2);
        countdown = 1'b0;
        step(10);
        chk("t4_pause", cnt, 16'h0005);
        countdown = 1'b1;
        step(1);
        chk("t4_res1", cnt, 16'h0005);
        step(1);
        chk("t4_res2", cnt, 16'h0004);

        // 5: clamped preset, start holds prescaler
        preset(4'd7, 4'd15, 4'd9, 4'd10);
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t5_clamp", cnt, 16'h7959);
        start = 1'b1;
        step(10);
        chk("t5_start", cnt, 16'h7959);
        start = 1'b0;
        step(3);
        chk("t5_c3", cnt, 16'h7959);
        step(1);
        chk("t5_c4", cnt, 16'h7958);

        // 6: async reset mid-count, then run at 00:00
        preset(4'd0, 4'd0, 4'd3, 4'd0);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        rst = 1'b0;
        #2;
        chk("t6_rcnt", cnt, 16'h0000);
        chk("t6_rzero", {15'd0, zero}, 16'd1);
        chk("t6_rendd", {15'd0, endd}, 16'd0);
        chk("t6_ralarm", {15'd0, alarm}, 16'd0);
        rst = 1'b1;
        step(1);
        preset(4'd0, 4'd0, 4'd0, 4'd0);
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("t6_ldendd", {15'd0, endd}, 16'd0);
        step(1);
        chk("t6_endd", {15'd0, endd}, 16'd1);
        chk("t6_alarm", {15'd0, alarm}, 16'd1);
        step(5);
        chk("t6_cnt", cnt, 16'h0000);
        chk("t6_hold", {15'd0, endd}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
